display_mux: RTL and testbench

Parametrised, time-multiplexed 7-segment display driver for N hexadecimal digits. It scans one digit per scan tick, decodes the hex nibble, and drives the shared segment bus and per-digit anodes. Updates are double-buffered, so a new value only takes effect at a frame boundary. The block supports per-digit enable, decimal points and optional leading-zero blanking. It sits between the switch/button logic and the board's 8-digit display, replacing the purely combinational group-select decoder.

---
 rtl/display_mux_pkg.sv | 28 ++
 rtl/display_mux_hex7seg.sv | 12 +
 rtl/display_mux.sv | 121 ++++++++++++
 tb/tb_display_mux.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/display_mux_pkg.sv
// Shared constants for the multiplexed 7-segment driver.
// Provides the active-high segment LUT, off-level helpers and index sizing.
package display_pkg;

   // Active-high {g,f,e,d,c,b,a} patterns; entry n is SEG_LUT[n].
   localparam logic [15:0][6:0] SEG_LUT = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   function automatic logic [7:0] an_off(input bit active_low);
      return active_low ? 8'hFF : 8'h00;
   endfunction

   function automatic logic [6:0] seg_off(input bit active_low);
      return active_low ? 7'h7F : 7'h00;
   endfunction

   function automatic logic dp_off(input bit active_low);
      return active_low ? 1'b1 : 1'b0;
   endfunction

   // Counter widths never collapse to zero bits, even for a single digit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/display_mux_hex7seg.sv
// Combinational hex nibble to active-high 7-segment pattern.
// Polarity is applied by the parent so this stays board-independent.
module hex7seg
   import display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/display_mux.sv
// Time-multiplexed N-digit hex display driver with a double-buffered value,
// per-digit enable/decimal point and optional leading-zero blanking.
module display_mux
   import display_pkg::*;
#(
   parameter int N_DIGITS   = 8,
   parameter int SCAN_DIV   = 100_000,
   parameter bit ACTIVE_LOW = 1'b1
)(
   input  logic                    CLK100MHZ,
   input  logic                    CPU_RESETN,
   input  logic [4*N_DIGITS-1:0]   DATA,
   input  logic [N_DIGITS-1:0]     DIGIT_EN,
   input  logic [N_DIGITS-1:0]     DP,
   input  logic                    BLANK_LZ,
   input  logic                    LOAD,
   output logic [N_DIGITS-1:0]     AN,
   output logic [6:0]              SEG,
   output logic                    DP_OUT,
   output logic                    FRAME_DONE
);

   localparam int IW = idx_width(N_DIGITS);
   localparam int PW = idx_width(SCAN_DIV);
   localparam logic [7:0]          AN_OFF8 = an_off(ACTIVE_LOW);
   localparam logic [N_DIGITS-1:0] AN_OFF  = AN_OFF8[N_DIGITS-1:0];
   localparam logic [6:0]          SEG_OFF = seg_off(ACTIVE_LOW);
   localparam logic                DP_OFF  = dp_off(ACTIVE_LOW);

   logic [PW-1:0]           pcnt;
   logic [IW-1:0]           idx;
   logic                    tick, boundary, wrap_q;
   logic [4*N_DIGITS-1:0]   act_data, pend_data;
   logic [N_DIGITS-1:0]     act_en, act_dp, pend_en, pend_dp;
   logic                    pend_v;
   logic [N_DIGITS-1:0]     blank, an_hot;
   logic [3:0]              nib;
   logic [6:0]              seg_raw, seg_on;
   logic                    lit, dp_on;

   assign tick     = (pcnt == PW'(SCAN_DIV - 1));
   assign boundary = tick && (idx == IW'(N_DIGITS - 1));

   // Leading-zero scan from the most significant digit downwards.
   always_comb begin
      logic zero_above;
      zero_above = 1'b1;
      blank      = '0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         if (i > 0 && BLANK_LZ && act_data[4*i +: 4] == 4'h0 && zero_above)
            blank[i] = 1'b1;
         if (act_en[i] && act_data[4*i +: 4] != 4'h0)
            zero_above = 1'b0;
      end
   end

   assign nib = act_data[4*idx +: 4];

   hex7seg u_hex7seg (
      .nibble (nib),
      .seg    (seg_raw)
   );

   always_comb begin
      an_hot      = '0;
      lit         = act_en[idx] && !blank[idx];
      an_hot[idx] = lit;
      seg_on      = lit ? seg_raw : 7'h00;
      dp_on       = lit && act_dp[idx];
   end

   // LOAD is a single-cycle strobe with no back-pressure: every asserted cycle
   // is accepted; at the frame boundary it bypasses pending and lands in active.
   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         pcnt       <= '0;
         idx        <= '0;
         wrap_q     <= 1'b0;
         pend_v     <= 1'b0;
         act_data   <= '0;
         act_en     <= '0;
         act_dp     <= '0;
         pend_data  <= '0;
         pend_en    <= '0;
         pend_dp    <= '0;
         AN         <= AN_OFF;
         SEG        <= SEG_OFF;
         DP_OUT     <= DP_OFF;
         FRAME_DONE <= 1'b0;
      end else begin
         pcnt <= tick ? '0 : pcnt + 1'b1;
         if (tick)
            idx <= boundary ? '0 : idx + 1'b1;

         if (boundary && LOAD) begin
            act_data <= DATA;
            act_en   <= DIGIT_EN;
            act_dp   <= DP;
            pend_v   <= 1'b0;
         end else if (boundary && pend_v) begin
            act_data <= pend_data;
            act_en   <= pend_en;
            act_dp   <= pend_dp;
            pend_v   <= 1'b0;
         end else if (LOAD) begin
            pend_data <= DATA;
            pend_en   <= DIGIT_EN;
            pend_dp   <= DP;
            pend_v    <= 1'b1;
         end

         // Outputs trail idx by one edge; FRAME_DONE is delayed to match.
         wrap_q     <= boundary;
         FRAME_DONE <= wrap_q;
         AN         <= an_hot ^ AN_OFF;
         SEG        <= seg_on ^ SEG_OFF;
         DP_OUT     <= dp_on ^ DP_OFF;
      end
   end

endmodule

// File: tb/tb_display_mux.sv
// Directed bench for display_mux with 4 digits, 4-cycle slots, active-low outputs.
// Positions are tracked in negedges relative to the FRAME_DONE sample.
module tb_display_mux;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] data;
   logic [3:0]  digit_en, dp;
   logic        blank_lz, load;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp_out, frame_done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   display_mux #(.N_DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1'b1)) dut (
      .CLK100MHZ  (clk),
      .CPU_RESETN (rst_n),
      .DATA       (data),
      .DIGIT_EN   (digit_en),
      .DP         (dp),
      .BLANK_LZ   (blank_lz),
      .LOAD       (load),
      .AN         (an),
      .SEG        (seg),
      .DP_OUT     (dp_out),
      .FRAME_DONE (frame_done)
   );

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                            input logic e_dp);
      check({tag, "_an"}, 32'(an), 32'(e_an));
      check({tag, "_seg"}, 32'(seg), 32'(e_seg));
      check({tag, "_dp"}, 32'(dp_out), 32'(e_dp));
   endtask

   task automatic wait_fd();
      int n;
      n = 0;
      do begin
         step(1);
         n++;
      end while (frame_done !== 1'b1 && n < 40);
      check("fd_seen", 32'(frame_done), 32'd1);
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] en, input logic [3:0] p);
      data     = d;
      digit_en = en;
      dp       = p;
      load     = 1'b1;
      step(1);
      load     = 1'b0;
   endtask

   // Load, then land on the second FRAME_DONE so the new value is surely active.
   task automatic load_and_show(input logic [15:0] d, input logic [3:0] en, input logic [3:0] p);
      do_load(d, en, p);
      wait_fd();
      wait_fd();
   endtask

   initial begin
      rst_n = 1'b0; data = '0; digit_en = '0; dp = '0; blank_lz = 1'b0; load = 1'b0;
      step(3);
      check_out("rst", 4'hF, 7'h7F, 1'b1);
      check("rst_fd", 32'(frame_done), 32'd0);
      rst_n = 1'b1;

      // 8A1F with dp on digit 1, loaded before the first boundary.
      do_load(16'h8A1F, 4'hF, 4'b0010);
      wait_fd();
      check_out("d0", 4'b1110, 7'h0E, 1'b1);
      step(1);
      check("fd_pulse", 32'(frame_done), 32'd0);
      step(3);
      check_out("d1", 4'b1101, 7'h79, 1'b0);
      step(4);
      check_out("d2", 4'b1011, 7'h08, 1'b1);
      step(4);
      check_out("d3", 4'b0111, 7'h00, 1'b1);
      step(4);
      check("fd_period", 32'(frame_done), 32'd1);
      check_out("d0_again", 4'b1110, 7'h0E, 1'b1);

      // Mid-frame load during the digit-1 slot.
      step(4);
      check_out("mid_d1", 4'b1101, 7'h79, 1'b0);
      do_load(16'h1234, 4'hF, 4'b0010);
      step(3);
      check_out("mid_d2_old", 4'b1011, 7'h08, 1'b1);
      step(4);
      check_out("mid_d3_old", 4'b0111, 7'h00, 1'b1);
      step(4);
      check("mid_fd", 32'(frame_done), 32'd1);
      check_out("mid_d0_new", 4'b1110, 7'h19, 1'b1);
      step(4);
      check_out("mid_d1_new", 4'b1101, 7'h30, 1'b0);

      // Leading-zero blanking.
      blank_lz = 1'b1;
      load_and_show(16'h0050, 4'hF, 4'b0000);
      check_out("lz_d0", 4'b1110, 7'h40, 1'b1);
      step(4);
      check_out("lz_d1", 4'b1101, 7'h12, 1'b1);
      step(4);
      check_out("lz_d2", 4'hF, 7'h7F, 1'b1);
      step(4);
      check_out("lz_d3", 4'hF, 7'h7F, 1'b1);

      load_and_show(16'h0000, 4'hF, 4'b0000);
      check_out("z_d0", 4'b1110, 7'h40, 1'b1);
      step(4);
      check_out("z_d1", 4'hF, 7'h7F, 1'b1);
      step(4);
      check_out("z_d2", 4'hF, 7'h7F, 1'b1);
      step(4);
      check_out("z_d3", 4'hF, 7'h7F, 1'b1);
      // BLANK_LZ acts as a live level.
      blank_lz = 1'b0;
      step(8);
      check_out("nolz_d1", 4'b1101, 7'h40, 1'b1);

      // Per-digit enable.
      load_and_show(16'h1234, 4'b0101, 4'b1111);
      check_out("en_d0", 4'b1110, 7'h19, 1'b0);
      step(4);
      check_out("en_d1", 4'hF, 7'h7F, 1'b1);
      step(4);
      check_out("en_d2", 4'b1011, 7'h24, 1'b0);
      step(4);
      check_out("en_d3", 4'hF, 7'h7F, 1'b1);

      // LOAD exactly on the boundary cycle: at FD+14 it is sampled by the wrap edge.
      step(2);
      do_load(16'hC0DE, 4'hF, 4'b0000);
      step(1);
      check("bnd_fd", 32'(frame_done), 32'd1);
      check_out("bnd_d0", 4'b1110, 7'h06, 1'b1);
      step(4);
      check_out("bnd_d1", 4'b1101, 7'h21, 1'b1);

      // Short reset mid-frame with a pending load outstanding.
      step(2);
      do_load(16'h7777, 4'hF, 4'hF);
      rst_n = 1'b0;
      step(1);
      check_out("rst2", 4'hF, 7'h7F, 1'b1);
      check("rst2_fd", 32'(frame_done), 32'd0);
      rst_n = 1'b1;
      wait_fd();
      wait_fd();
      check_out("lost_d0", 4'hF, 7'h7F, 1'b1);
      step(4);
      check_out("lost_d1", 4'hF, 7'h7F, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
